// File: rtl/if_fetch_unit_pkg.sv
// Constants shared by the fetch unit, the instruction ROM and the exception unit.
// Also holds the next-PC source encoding and the fetch address-error rule.
package if_fetch_unit_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE     = 32'h0000_3000;
  localparam int          IM_WORDS    = 2048;
  localparam logic [31:0] IM_LIMIT    = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_REDIR,
    SEL_STALL,
    SEL_SEQ
  } npc_sel_e;

  // A fetch address is bad if it is misaligned or outside [base, limit].
  function automatic logic pc_addr_err(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
    return (a[1:0] != 2'b00) || (a < base) || (a > limit);
  endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC selection for the fetch unit: resolves the exception / eret /
// redirect / stall / sequential priority and drives the register controls.
module if_npc_sel
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC_P = HANDLER_VEC
) (
  input  logic [31:0] i_pc,
  input  logic        i_in_handler,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic        i_stall,
  output logic [31:0] o_npc,
  output logic        o_flush,
  output logic        o_hold,
  output logic        o_set_handler,
  output logic        o_clr_handler
);

  npc_sel_e w_sel;

  // Exceptions are not nested: a request inside the handler falls through.
  always_comb begin
    w_sel = SEL_SEQ;
    if (i_exc_req && !i_in_handler) w_sel = SEL_EXC;
    else if (i_eret_req)            w_sel = SEL_ERET;
    else if (i_redirect_valid)      w_sel = SEL_REDIR;
    else if (i_stall)               w_sel = SEL_STALL;
  end

  always_comb begin
    o_npc         = i_pc + 32'd4;
    o_flush       = 1'b0;
    o_hold        = 1'b0;
    o_set_handler = 1'b0;
    o_clr_handler = 1'b0;
    case (w_sel)
      SEL_EXC: begin
        o_npc         = HANDLER_VEC_P;
        o_flush       = 1'b1;
        o_set_handler = 1'b1;
      end
      SEL_ERET: begin
        o_npc         = i_epc;
        o_flush       = 1'b1;
        o_clr_handler = 1'b1;
      end
      SEL_REDIR: begin
        o_npc   = i_redirect_target;
        o_flush = 1'b1;
      end
      SEL_STALL: begin
        o_npc  = i_pc;
        o_hold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, ROM address, IF/ID register
// and handler-active flag, with the next PC chosen by if_npc_sel.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET_P    = PC_RESET,
  parameter logic [31:0] HANDLER_VEC_P = HANDLER_VEC,
  parameter logic [31:0] IM_BASE_P     = IM_BASE,
  parameter int          IM_WORDS_P    = IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        addr_err,
  output logic        in_handler
);

  localparam logic [31:0] LIMIT = IM_BASE_P + 32'(4 * IM_WORDS_P) - 32'd4;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_in_handler;

  logic [31:0] w_pc4;
  logic        w_addr_err;
  logic [31:0] w_npc;
  logic        w_flush;
  logic        w_hold;
  logic        w_set_handler;
  logic        w_clr_handler;

  assign w_pc4      = r_pc + 32'd4;
  assign w_addr_err = pc_addr_err(r_pc, IM_BASE_P, LIMIT);

  if_npc_sel #(
    .HANDLER_VEC_P (HANDLER_VEC_P)
  ) u_npc_sel (
    .i_pc              (r_pc),
    .i_in_handler      (r_in_handler),
    .i_exc_req         (exc_req),
    .i_eret_req        (eret_req),
    .i_epc             (epc),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_stall           (stall),
    .o_npc             (w_npc),
    .o_flush           (w_flush),
    .o_hold            (w_hold),
    .o_set_handler     (w_set_handler),
    .o_clr_handler     (w_clr_handler)
  );

  // A flush zeroes the instruction but keeps the last pc4 for debug visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= PC_RESET_P;
      r_instr      <= NOP_WORD;
      r_pc4        <= 32'd0;
      r_valid      <= 1'b0;
      r_in_handler <= 1'b0;
    end else begin
      if (!w_hold) r_pc <= w_npc;
      if (w_flush) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (!w_hold) begin
        r_instr <= w_addr_err ? NOP_WORD : im_dout;
        r_pc4   <= w_pc4;
        r_valid <= !w_addr_err;
      end
      if (w_set_handler)      r_in_handler <= 1'b1;
      else if (w_clr_handler) r_in_handler <= 1'b0;
    end
  end

  assign im_addr     = r_pc;
  assign pc          = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign addr_err    = w_addr_err;
  assign in_handler  = r_in_handler;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, then randomized cycles
// checked against a cycle-level reference model of the fetch rules.
module tb_if_fetch_unit;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] TOP    = 32'h0000_4FFC;
  localparam logic [31:0] GARBGE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        addr_err;
  logic        in_handler;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .im_addr         (im_addr),
    .im_dout         (im_dout),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .addr_err        (addr_err),
    .in_handler      (in_handler)
  );

  // ROM model: word i = C0DE_<i>, except word 0; illegal addresses return garbage.
  logic [31:0] rom [0:2047];
  logic [31:0] rom_off;
  assign rom_off = im_addr - BASE;
  assign im_dout = bad_addr(im_addr) ? GARBGE : rom[rom_off[12:2]];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a > TOP);
  endfunction

  typedef struct {
    logic        rst, stl, rv;
    logic [31:0] rt;
    logic        exc, eret;
    logic [31:0] ep;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_inh, e_aerr;
  } vec_t;

  vec_t vecs [25];

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_inh,
                           input logic e_aerr);
    chk32({tag, " pc"}, pc, e_pc);
    chk32({tag, " im_addr"}, im_addr, e_pc);
    chk32({tag, " instr"}, if_id_instr, e_instr);
    chk32({tag, " pc4"}, if_id_pc4, e_pc4);
    chk1({tag, " valid"}, if_id_valid, e_valid);
    chk1({tag, " in_handler"}, in_handler, e_inh);
    chk1({tag, " addr_err"}, addr_err, e_aerr);
  endtask

  // Reference model state: the architectural view of the fetch unit.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_inh;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return bad_addr(a) ? GARBGE : rom[off[10:0]];
  endfunction

  task automatic model_step();
    logic bad;
    bad = bad_addr(m_pc);
    if (reset) begin
      m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_inh = 0;
    end else if (exc_req && !m_inh) begin
      m_pc = 32'h4180; m_inh = 1; m_instr = 0; m_valid = 0;
    end else if (eret_req) begin
      m_pc = epc; m_inh = 0; m_instr = 0; m_valid = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_instr = 0; m_valid = 0;
    end else if (!stall) begin
      m_instr = bad ? 32'h0 : rom_word(m_pc);
      m_pc4   = m_pc + 4;
      m_valid = !bad;
      m_pc    = m_pc + 4;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return BASE + 32'($urandom_range(0, 2047)) * 32'd4;
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = {16'hC0DE, 16'(i)};
    rom[0] = 32'h2001_0005;

    // '{rst,stall,rv,target,exc,eret,epc, pc,instr,pc4,valid,in_handler,addr_err}
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3000,32'h0,32'h0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3004,32'h2001_0005,32'h3004,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3008,32'hC0DE_0001,32'h3008,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3008,32'hC0DE_0001,32'h3008,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3008,32'hC0DE_0001,32'h3008,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h300C,32'hC0DE_0002,32'h300C,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,32'h3040,1'b0,1'b0,32'h0,   32'h3040,32'h0,32'h300C,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3044,32'hC0DE_0010,32'h3044,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h3010,1'b0,1'b0,32'h0,   32'h3010,32'h0,32'h3044,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,   32'h4180,32'h0,32'h3044,1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,   32'h4184,32'hC0DE_0460,32'h4184,1'b1,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,32'h3014,32'h3014,32'h0,32'h4184,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3018,32'hC0DE_0005,32'h3018,1'b1,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,32'h3002,1'b0,1'b0,32'h0,   32'h3002,32'h0,32'h3018,1'b0,1'b0,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h3006,32'h0,32'h3006,1'b0,1'b0,1'b1};
    vecs[15] = '{1'b0,1'b0,1'b1,32'h5000,1'b0,1'b0,32'h0,   32'h5000,32'h0,32'h3006,1'b0,1'b0,1'b1};
    vecs[16] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h5004,32'h0,32'h5004,1'b0,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b0,1'b1,32'h4FFC,1'b0,1'b0,32'h0,   32'h4FFC,32'h0,32'h5004,1'b0,1'b0,1'b0};
    vecs[18] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h5000,32'hC0DE_07FF,32'h5000,1'b1,1'b0,1'b1};
    vecs[19] = '{1'b0,1'b0,1'b1,32'h2FFC,1'b0,1'b0,32'h0,   32'h2FFC,32'h0,32'h5000,1'b0,1'b0,1'b1};
    vecs[20] = '{1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h3020,32'h4180,32'h0,32'h5000,1'b0,1'b1,1'b0};
    vecs[21] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h4180,32'h0,32'h5000,1'b0,1'b1,1'b0};
    vecs[22] = '{1'b1,1'b1,1'b0,32'h0,   1'b1,1'b0,32'h0,   32'h3000,32'h0,32'h0,1'b0,1'b0,1'b0};
    vecs[23] = '{1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0, 32'hFFFF_FFFC,32'h0,32'h0,1'b0,1'b0,1'b1};
    vecs[24] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,   32'h0,32'h0,32'h0,1'b0,1'b0,1'b1};

    for (int v = 0; v < 25; v++) begin
      reset = vecs[v].rst; stall = vecs[v].stl;
      redirect_valid = vecs[v].rv; redirect_target = vecs[v].rt;
      exc_req = vecs[v].exc; eret_req = vecs[v].eret; epc = vecs[v].ep;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", v), vecs[v].e_pc, vecs[v].e_instr, vecs[v].e_pc4,
                vecs[v].e_valid, vecs[v].e_inh, vecs[v].e_aerr);
      $display("vec %0d: pc=%h instr=%h pc4=%h valid=%b inh=%b aerr=%b",
               v, pc, if_id_instr, if_id_pc4, if_id_valid, in_handler, addr_err);
    end

    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_inh = 0;
    for (int n = 0; n < 300; n++) begin
      reset           = (n == 0) || ($urandom_range(0, 99) < 3);
      exc_req         = $urandom_range(0, 99) < 8;
      eret_req        = $urandom_range(0, 99) < 6;
      redirect_valid  = $urandom_range(0, 99) < 15;
      stall           = $urandom_range(0, 99) < 25;
      redirect_target = rand_addr();
      epc             = rand_addr();
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_valid, m_inh, bad_addr(m_pc));
      $display("rnd %0d: rst=%b exc=%b eret=%b rv=%b stall=%b -> pc=%h instr=%h valid=%b inh=%b",
               n, reset, exc_req, eret_req, redirect_valid, stall, pc, if_id_instr,
               if_id_valid, in_handler);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end; the requesting side of the instruction-memory interface.
- Holds the PC and presents a byte address to the combinational instruction ROM (base 0x0000_3000, 2048 words).
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, exception entry to the handler vector, eret return, and address-error detection.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- HANDLER_VEC, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 2048, ROM depth in words. Highest legal address = IM_BASE + 4*IM_WORDS - 4 = 0x4FFC.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- stall  in  1  hazard stall from decode: hold PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC for redirect.
- exc_req  in  1  exception request from a later stage.
- eret_req  in  1  return from handler.
- epc  in  32  return address used by eret.
- im_addr  out  32  fetch byte address to the instruction ROM; equals pc.
- im_dout  in  32  instruction word from the ROM, combinational on im_addr.
- pc  out  32  current PC.
- if_id_instr  out  32  latched instruction.
- if_id_pc4  out  32  latched PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- addr_err  out  1  current pc is misaligned or outside the ROM range (combinational).
- in_handler  out  1  exception handler active.

Behaviour:
Reset:
- All state updates on posedge clk.
- reset=1 at an edge loads pc=PC_RESET, if_id_instr=0, if_id_pc4=0, if_id_valid=0, in_handler=0.
- Reset wins over every other input, including mid-redirect or mid-handler.

Next-PC priority, highest first:
1. exc_req && !in_handler: pc<=HANDLER_VEC; in_handler<=1; flush IF/ID.
2. eret_req: pc<=epc; in_handler<=0; flush IF/ID.
3. redirect_valid: pc<=redirect_target; flush IF/ID.
4. stall: pc and IF/ID hold.
5. Otherwise: pc<=pc+4; IF/ID<=im_dout, pc+4, valid=!addr_err.

Exception and eret rules:
- Priorities 1–3 override stall.
- exc_req while in_handler=1 is ignored (no nesting); the other inputs are then evaluated normally.
- exc_req and eret_req in the same cycle with in_handler=0: the exception wins.

Flush and address error:
- Flush means if_id_instr<=0 (NOP), if_id_valid<=0, and if_id_pc4 unchanged.
- addr_err=1 when pc[1:0]!=0, pc<IM_BASE, or pc>0x4FFC.
- When addr_err=1 the fetched word is not trusted: the sequential load writes if_id_instr=0 and if_id_valid=0. The PC still advances.
- The fetch unit does not raise the exception itself; the downstream stage samples addr_err and asserts exc_req.

Arithmetic and latency:
- pc+4 is 32-bit modulo; wrap from 0xFFFF_FFFC to 0 is permitted and flagged by addr_err.
- im_addr is a direct copy of pc. The ROM index is (im_addr-IM_BASE)[12:2], computed inside the ROM, not here.
- Latency: an instruction at pc appears on if_id_instr one edge later.
- A redirect takes effect at the next edge. The first instruction from the new target appears one edge after that.

Decomposition:
- Shared package holds PC_RESET, HANDLER_VEC, IM_BASE, IM_LIMIT (0x4FFC) and NOP_WORD (0). The ROM and the exception unit use the same constants.
- One natural sub-module: if_npc_sel. It is purely combinational and takes the priority inputs, pc and in_handler. It outputs npc, flush, hold, set_handler and clr_handler.
- The PC, IF/ID and in_handler registers stay in the top module.

Test Plan:
1. Reset, then 4 free-running cycles with the ROM holding 0x2001_0005 at 0x3000 -> pc goes 3000,3004,3008,300C. The first IF/ID shows instr=0x2001_0005, pc4=0x3004, valid=1.
2. stall=1 for 2 cycles at pc=0x3008 -> pc and IF/ID unchanged for both edges. The stream resumes at 0x300C after release.
3. redirect_valid=1 with target 0x3040 while stall=1 -> pc=0x3040 and IF/ID flushed (instr=0, valid=0). The next edge loads the word at 0x3040.
4. exc_req at pc=0x3010 -> pc=0x4180, in_handler=1, flush. A second exc_req in the handler is ignored. eret with epc=0x3014 -> pc=0x3014, in_handler=0.
5. redirect_target=0x3002, then separately 0x5000 -> addr_err=1, next IF/ID valid=0 with instr=0. exc_req and eret_req asserted together with in_handler=0 -> pc=0x4180.
6. reset asserted while in_handler=1 and stall=1 -> pc=0x3000, in_handler=0, if_id_valid=0 on that edge.
